// File: rtl/fifo_write_arbiter_if.sv
// Handshake bundle between NUM_REQ producers, the write arbiter and one FIFO write port.
// The arbiter connects through the slave modport; producers and the FIFO sit on the master side.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PAR_WRITE  = 1
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req;
    logic [DATA_WIDTH-1:0] req_data [NUM_REQ][PAR_WRITE];
    logic [NUM_REQ-1:0]    ack;
    logic [DATA_WIDTH-1:0] fifo_data [PAR_WRITE];
    logic                  fifo_write_enable;
    logic                  fifo_ready;
    logic [ID_W-1:0]       grant_id;
    logic                  busy;

    modport master (
        output req, req_data, fifo_ready,
        input  ack, fifo_data, fifo_write_enable, grant_id, busy
    );

    modport slave (
        input  req, req_data, fifo_ready,
        output ack, fifo_data, fifo_write_enable, grant_id, busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A grant lasts up to BURST accepted writes, then priority moves past the granted producer.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PAR_WRITE  = 1,
    parameter int BURST      = 4
) (
    input logic                 clk,
    input logic                 rst,
    fifo_write_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST + 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  next_grant;
    logic [ID_W-1:0]  grant_succ;
    logic [CNT_W-1:0] burst_cnt;
    logic             busy_q;
    logic             write_en;
    logic             accept;
    logic             last_beat;

    // Scan downwards so the producer closest to rr_ptr is the last (winning) assignment.
    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    always_comb begin : pick_next
        logic [ID_W-1:0] idx;
        next_grant = rr_ptr;
        idx        = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (bus.req[idx]) next_grant = idx;
        end
    end

    assign grant_succ = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign last_beat  = (burst_cnt == CNT_W'(BURST - 1));

    // Derived from the async-reset state, so reset kills the write strobe without a clock edge.
    assign write_en = (state == XFER) && bus.req[grant_id];
    assign accept   = write_en && bus.fifo_ready;

    assign bus.fifo_write_enable = write_en;
    assign bus.grant_id          = grant_id;
    assign bus.busy              = busy_q;

    always_comb begin
        bus.ack = '0;
        if (accept) bus.ack[grant_id] = 1'b1;
    end

    always_comb begin
        for (int w = 0; w < PAR_WRITE; w++) begin
            bus.fifo_data[w] = bus.req_data[grant_id][w];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        grant_id  <= next_grant;
                        burst_cnt <= '0;
                        state     <= XFER;
                        busy_q    <= 1'b1;
                    end
                end
                XFER: begin
                    // Withdrawal and burst exhaustion both hand priority to the next index.
                    if (!bus.req[grant_id] || (accept && last_beat)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        rr_ptr <= grant_succ;
                    end else if (accept) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: a BURST=4 and a BURST=1 arbiter run against an ownership/credit model,
// with directed phases for reset, rotation, burst limit, backpressure, withdrawal and async reset.
module tb_fifo_write_arbiter;
    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int PW   = 2;
    localparam int ID_W = 2;

    typedef struct {
        int id;
        int cyc;
        int word;
    } acc_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .PAR_WRITE(PW)) bus0 ();
    fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .PAR_WRITE(PW)) bus1 ();

    fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .PAR_WRITE(PW), .BURST(4)) u_b4 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .PAR_WRITE(PW), .BURST(1)) u_b1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    // Producer / FIFO stimulus per instance (0: BURST=4, 1: BURST=1)
    logic [N-1:0]    req_v [2];
    logic            rdy_v [2];
    logic [DW-1:0]   pay   [2][N][PW];

    logic [N-1:0]    o_ack  [2];
    logic            o_we   [2];
    logic            o_busy [2];
    logic [ID_W-1:0] o_gid  [2];
    logic [DW-1:0]   o_data [2][PW];

    always_comb begin
        bus0.req        = req_v[0];
        bus1.req        = req_v[1];
        bus0.fifo_ready = rdy_v[0];
        bus1.fifo_ready = rdy_v[1];
        for (int i = 0; i < N; i++) begin
            for (int w = 0; w < PW; w++) begin
                bus0.req_data[i][w] = pay[0][i][w];
                bus1.req_data[i][w] = pay[1][i][w];
            end
        end
    end

    always_comb begin
        o_ack[0]  = bus0.ack;               o_ack[1]  = bus1.ack;
        o_we[0]   = bus0.fifo_write_enable; o_we[1]   = bus1.fifo_write_enable;
        o_busy[0] = bus0.busy;              o_busy[1] = bus1.busy;
        o_gid[0]  = bus0.grant_id;          o_gid[1]  = bus1.grant_id;
        for (int w = 0; w < PW; w++) begin
            o_data[0][w] = bus0.fifo_data[w];
            o_data[1][w] = bus1.fifo_data[w];
        end
    end

    // Reference model: who owns the port (-1 = nobody), how many writes it may still make,
    // where the priority scan starts, and the last producer granted.
    int           m_owner [2];
    int           m_left  [2];
    int           m_ptr   [2];
    int           m_last  [2];
    logic [N-1:0] acked   [2];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   auto_mode = 1'b0;
    bit   streaming   [2][N];
    int   stream_left [2][N];
    acc_t acc0 [$];
    acc_t acc1 [$];

    function automatic int burst_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset(input int k);
        m_owner[k] = -1;
        m_left[k]  = 0;
        m_ptr[k]   = 0;
        m_last[k]  = 0;
        acked[k]   = '0;
    endtask

    task automatic release_port(input int k);
        m_ptr[k]   = (m_owner[k] + 1) % N;
        m_owner[k] = -1;
    endtask

    task automatic compare_and_advance(input int k);
        logic [N-1:0] e_ack;
        logic         e_we;
        acc_t         e;
        if (!rst) model_reset(k);
        e_we = 1'b0;
        if (m_owner[k] >= 0) e_we = req_v[k][m_owner[k]];
        e_ack = '0;
        if (e_we && rdy_v[k]) e_ack[m_owner[k]] = 1'b1;

        check($sformatf("i%0d ack", k),  o_ack[k],  e_ack);
        check($sformatf("i%0d we", k),   o_we[k],   e_we);
        check($sformatf("i%0d busy", k), o_busy[k], m_owner[k] >= 0);
        check($sformatf("i%0d gid", k),  o_gid[k],  m_last[k]);
        for (int w = 0; w < PW; w++) begin
            check($sformatf("i%0d data%0d", k, w), o_data[k][w], pay[k][m_last[k]][w]);
        end
        if (!rst) return;

        acked[k] = e_ack;
        if (e_ack != '0) begin
            e.id   = m_owner[k];
            e.cyc  = cyc;
            e.word = int'(pay[k][m_owner[k]][0]);
            if (k == 0) acc0.push_back(e);
            else        acc1.push_back(e);
        end

        if (m_owner[k] < 0) begin
            for (int j = 0; j < N; j++) begin
                int c;
                c = (m_ptr[k] + j) % N;
                if (req_v[k][c]) begin
                    m_owner[k] = c;
                    m_last[k]  = c;
                    m_left[k]  = burst_of(k);
                    break;
                end
            end
        end else if (!req_v[k][m_owner[k]]) begin
            release_port(k);
        end else if (e_ack != '0) begin
            m_left[k]--;
            if (m_left[k] == 0) release_port(k);
        end
    endtask

    task automatic new_payload(input int k, input int i);
        for (int w = 0; w < PW; w++) pay[k][i][w] = DW'($urandom);
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                if (auto_mode) begin
                    if (acked[k][i]) begin
                        new_payload(k, i);
                        req_v[k][i] = ($urandom_range(3) != 0);
                    end else if (req_v[k][i]) begin
                        if ($urandom_range(15) == 0) req_v[k][i] = 1'b0;
                    end else if ($urandom_range(2) == 0) begin
                        new_payload(k, i);
                        req_v[k][i] = 1'b1;
                    end
                end else if (acked[k][i]) begin
                    if (streaming[k][i]) begin
                        stream_left[k][i]--;
                        if (stream_left[k][i] == 0) begin
                            streaming[k][i] = 1'b0;
                            req_v[k][i]     = 1'b0;
                        end else begin
                            pay[k][i][0] = pay[k][i][0] + 8'd1;
                            pay[k][i][1] = ~pay[k][i][0];
                        end
                    end else begin
                        new_payload(k, i);
                    end
                end
            end
            if (auto_mode) rdy_v[k] = ($urandom_range(3) != 0);
        end
    endtask

    // One clock: compare and advance the model on the falling edge, then drive after the rising edge.
    task automatic step();
        @(negedge clk);
        compare_and_advance(0);
        compare_and_advance(1);
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
    endtask

    task automatic start_stream(input int i, input logic [DW-1:0] first, input int count);
        pay[0][i][0]      = first;
        pay[0][i][1]      = ~first;
        streaming[0][i]   = 1'b1;
        stream_left[0][i] = count;
        req_v[0][i]       = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_v[k] = 4'b1111;
            rdy_v[k] = 1'b1;
            model_reset(k);
            for (int i = 0; i < N; i++) begin
                new_payload(k, i);
                streaming[k][i]   = 1'b0;
                stream_left[k][i] = 0;
            end
        end

        // Reset held with every producer requesting
        repeat (3) step();
        check("rst we",   bus0.fifo_write_enable, 0);
        check("rst busy", bus0.busy, 0);
        check("rst gid",  bus0.grant_id, 0);
        check("rst ack",  bus0.ack, 0);
        check("rst data", bus0.fifo_data[0], pay[0][0][0]);

        // Release: one arbitration cycle, then producer 0 owns the port
        rst = 1'b1;
        acc0.delete();
        acc1.delete();
        step();
        check("rel busy", bus0.busy, 1);
        check("rel gid",  bus0.grant_id, 0);
        check("rel we",   bus0.fifo_write_enable, 1);
        check("rel gid b1", bus1.grant_id, 0);
        repeat (19) step();

        // BURST=1 rotates every word; BURST=4 rotates every four words; one idle cycle between grants
        check("rr b1 count", acc1.size() >= 8, 1);
        check("rr b4 count", acc0.size() >= 8, 1);
        for (int j = 0; j < 8; j++) begin
            if (j < acc1.size()) check($sformatf("rr b1 id%0d", j), acc1[j].id, j % 4);
            if (j < acc0.size()) check($sformatf("rr b4 id%0d", j), acc0[j].id, j / 4);
            if (j > 0 && j < acc1.size())
                check($sformatf("rr b1 gap%0d", j), acc1[j].cyc - acc1[j-1].cyc, 2);
            if (j > 0 && j < acc0.size())
                check($sformatf("rr b4 gap%0d", j), acc0[j].cyc - acc0[j-1].cyc, (j == 4) ? 2 : 1);
        end

        // Burst limit: producer 2 alone streams 0x10..0x17
        req_v[0] = '0;
        req_v[1] = '0;
        repeat (2) step();
        acc0.delete();
        start_stream(2, 8'h10, 8);
        repeat (14) step();
        check("burst count", acc0.size(), 8);
        for (int j = 0; j < 8; j++) begin
            if (j < acc0.size()) begin
                check($sformatf("burst word%0d", j), acc0[j].word, 8'h10 + j);
                if (j > 0) check($sformatf("burst gap%0d", j), acc0[j].cyc - acc0[j-1].cyc, (j == 4) ? 2 : 1);
            end
        end

        // Backpressure: five stalled cycles after the first word of a burst
        acc0.delete();
        start_stream(2, 8'h20, 6);
        repeat (2) step();
        rdy_v[0] = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            check("stall we",   bus0.fifo_write_enable, 1);
            check("stall data", bus0.fifo_data[0], 8'h21);
            check("stall ack",  bus0.ack, 0);
        end
        check("stall count", acc0.size(), 1);
        rdy_v[0] = 1'b1;
        repeat (10) step();
        check("resume count", acc0.size(), 6);
        for (int j = 0; j < 6; j++) begin
            if (j < acc0.size()) check($sformatf("resume word%0d", j), acc0[j].word, 8'h20 + j);
        end

        // Withdrawal of producer 3 with producer 0 waiting; priority wraps to 0
        acc0.delete();
        rdy_v[0] = 1'b0;
        req_v[0] = 4'b1001;
        step();
        check("wd gid3",  bus0.grant_id, 3);
        check("wd busy",  bus0.busy, 1);
        step();
        req_v[0] = 4'b0001;
        step();
        check("wd idle",  bus0.busy, 0);
        step();
        check("wd gid0",  bus0.grant_id, 0);
        check("wd busy0", bus0.busy, 1);
        check("wd no ack", acc0.size(), 0);
        req_v[0] = '0;
        rdy_v[0] = 1'b1;
        repeat (2) step();

        // Asynchronous reset between edges during a burst
        req_v[0] = 4'b0010;
        repeat (3) step();
        #2;
        rst = 1'b0;
        #1;
        check("arst we",   bus0.fifo_write_enable, 0);
        check("arst ack",  bus0.ack, 0);
        check("arst busy", bus0.busy, 0);
        req_v[0] = 4'b0011;
        acc0.delete();
        repeat (2) step();
        rst = 1'b1;
        check("arst no write", acc0.size(), 0);
        step();
        check("arst gid0", bus0.grant_id, 0);
        check("arst busy1", bus0.busy, 1);

        // Randomized traffic, backpressure and withdrawals, with one more mid-cycle reset
        auto_mode = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (c == 2000) begin
                #2;
                rst = 1'b0;
                #1;
                check("rnd arst we0", bus0.fifo_write_enable, 0);
                check("rnd arst we1", bus1.fifo_write_enable, 0);
                repeat (2) step();
                rst = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
